udc_seg_reader: RTL and testbench

//  Reads the UDC seven-segment output (seg/dp/view) and turns it back into a 4-bit count.

---
 rtl/udc_seg_reader.sv | 188 ++++++++++++++++++
 tb/tb_udc_seg_reader.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/udc_seg_reader.sv
// Reads back the UDC seven-segment display, recovers the 4-bit count and checks
// every new value for glyph legality, a +/-1 modulo-16 step and commanded direction.
module udc_seg_reader #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg,
  input  logic             dp,
  input  logic             view,
  input  logic             up,
  output logic [3:0]       digit,
  output logic             digit_dp,
  output logic             digit_valid,
  output logic             dir,
  output logic             accept,
  output logic             illegal,
  output logic             step_err,
  output logic             dir_err,
  output logic [CNT_W-1:0] chg_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int SCNT_W = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STABLE_CYCLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_ARM = SCNT_W'(STABLE_CYCLES - 2);
  localparam logic [6:0]        BLANK    = 7'h7F;

  typedef enum logic {
    ST_WAIT,
    ST_TRACK
  } state_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] val;
  } glyph_t;

  // Active-low abcdefg glyph table; anything not listed is not a hex digit.
  function automatic glyph_t decode(input logic [6:0] pat);
    glyph_t g;
    g.legal = 1'b1;
    case (pat)
      7'b0000001: g.val = 4'h0;
      7'b1001111: g.val = 4'h1;
      7'b0010010: g.val = 4'h2;
      7'b0000110: g.val = 4'h3;
      7'b1001100: g.val = 4'h4;
      7'b0100100: g.val = 4'h5;
      7'b0100000: g.val = 4'h6;
      7'b0001111: g.val = 4'h7;
      7'b0000000: g.val = 4'h8;
      7'b0000100: g.val = 4'h9;
      7'b0001000: g.val = 4'hA;
      7'b1100000: g.val = 4'hB;
      7'b0110001: g.val = 4'hC;
      7'b1000010: g.val = 4'hD;
      7'b0110000: g.val = 4'hE;
      7'b0111000: g.val = 4'hF;
      default: begin
        g.legal = 1'b0;
        g.val   = 4'h0;
      end
    endcase
    return g;
  endfunction

  logic [6:0]        cand;
  logic [6:0]        acc_pat;
  logic [SCNT_W-1:0] scnt;
  logic              same;
  logic              event_fire;
  glyph_t            cand_g;

  state_t state, state_nxt;

  logic [3:0] digit_nxt;
  logic       digit_dp_nxt;
  logic       digit_valid_nxt;
  logic       dir_nxt;
  logic       accept_nxt;
  logic       illegal_nxt;
  logic       step_err_nxt;
  logic       dir_err_nxt;
  logic       any_err_nxt;

  // An event fires exactly once per steady run, on the edge the run reaches
  // STABLE_CYCLES samples, and only for a non-blank pattern not already accepted.
  always_comb begin
    same       = (seg == cand);
    cand_g     = decode(cand);
    event_fire = view && same && (scnt == SCNT_ARM) &&
                 (cand != acc_pat) && (cand != BLANK);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      cand    <= BLANK;
      scnt    <= '0;
      acc_pat <= BLANK;
    end else if (!view) begin
      cand <= BLANK;
      scnt <= '0;
    end else if (!same) begin
      cand <= seg;
      scnt <= '0;
    end else begin
      if (scnt != SCNT_MAX) scnt <= scnt + 1'b1;
      if (event_fire)       acc_pat <= cand;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_WAIT;
    else       state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    if (event_fire && cand_g.legal) state_nxt = ST_TRACK;
  end

  always_comb begin
    digit_nxt       = digit;
    digit_dp_nxt    = digit_dp;
    digit_valid_nxt = digit_valid;
    dir_nxt         = dir;
    accept_nxt      = 1'b0;
    illegal_nxt     = 1'b0;
    step_err_nxt    = 1'b0;
    dir_err_nxt     = 1'b0;
    if (event_fire) begin
      if (!cand_g.legal) begin
        illegal_nxt = 1'b1;
      end else begin
        accept_nxt      = 1'b1;
        digit_nxt       = cand_g.val;
        digit_dp_nxt    = ~dp;
        digit_valid_nxt = 1'b1;
        if (state == ST_TRACK) begin
          // 4-bit arithmetic wraps, so F->0 is up and 0->F is down.
          if (cand_g.val == digit + 4'd1) begin
            dir_nxt     = 1'b1;
            dir_err_nxt = ~up;
          end else if (cand_g.val == digit - 4'd1) begin
            dir_nxt     = 1'b0;
            dir_err_nxt = up;
          end else begin
            step_err_nxt = 1'b1;
          end
        end
      end
    end
    any_err_nxt = illegal_nxt | step_err_nxt | dir_err_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digit       <= 4'h0;
      digit_dp    <= 1'b0;
      digit_valid <= 1'b0;
      dir         <= 1'b0;
      accept      <= 1'b0;
      illegal     <= 1'b0;
      step_err    <= 1'b0;
      dir_err     <= 1'b0;
      chg_cnt     <= '0;
      err_cnt     <= '0;
    end else begin
      digit       <= digit_nxt;
      digit_dp    <= digit_dp_nxt;
      digit_valid <= digit_valid_nxt;
      dir         <= dir_nxt;
      accept      <= accept_nxt;
      illegal     <= illegal_nxt;
      step_err    <= step_err_nxt;
      dir_err     <= dir_err_nxt;
      if (accept_nxt && (chg_cnt != '1)) chg_cnt <= chg_cnt + 1'b1;
      if (any_err_nxt && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_udc_seg_reader.sv
// Self-checking bench for udc_seg_reader: directed vector table, hand-written
// latency sequences and randomized stimulus against a run-length reference model.
module tb_udc_seg_reader;

  localparam int STABLE  = 4;
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  localparam logic [6:0] BLANK = 7'h7F;

  logic             clk = 1'b0;
  logic             reset;
  logic [6:0]       seg;
  logic             dp;
  logic             view;
  logic             up;
  logic [3:0]       digit;
  logic             digit_dp;
  logic             digit_valid;
  logic             dir;
  logic             accept;
  logic             illegal;
  logic             step_err;
  logic             dir_err;
  logic [CNT_W-1:0] chg_cnt;
  logic [CNT_W-1:0] err_cnt;

  always #10 clk = ~clk;

  udc_seg_reader #(.STABLE_CYCLES(STABLE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .seg(seg), .dp(dp), .view(view), .up(up),
    .digit(digit), .digit_dp(digit_dp), .digit_valid(digit_valid), .dir(dir),
    .accept(accept), .illegal(illegal), .step_err(step_err), .dir_err(dir_err),
    .chg_cnt(chg_cnt), .err_cnt(err_cnt)
  );

  logic [6:0] glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a display value is seen once it has been sampled STABLE
  // times in a row with view=1; it is then judged against the last seen value.
  int         m_run   = 0;
  logic [6:0] m_last  = BLANK;
  logic [6:0] m_acc   = BLANK;
  int         m_digit = 0;
  int         m_dp = 0, m_valid = 0, m_dir = 0;
  int         m_accept = 0, m_illegal = 0, m_step = 0, m_dirr = 0;
  int         m_chg = 0, m_err = 0;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return i;
    return -1;
  endfunction

  task automatic model_edge();
    int v;
    m_accept = 0; m_illegal = 0; m_step = 0; m_dirr = 0;
    if (reset) begin
      m_run = 0; m_last = BLANK; m_acc = BLANK;
      m_digit = 0; m_dp = 0; m_valid = 0; m_dir = 0; m_chg = 0; m_err = 0;
      return;
    end
    if (!view) begin
      m_run = 0; m_last = BLANK;
      return;
    end
    if (seg == m_last) m_run++;
    else begin
      m_last = seg;
      m_run  = 1;
    end
    if (m_run == STABLE && seg != BLANK && seg != m_acc) begin
      m_acc = seg;
      v = lookup(seg);
      if (v < 0) m_illegal = 1;
      else begin
        m_accept = 1;
        m_dp     = dp ? 0 : 1;
        if (m_valid != 0) begin
          if (v == (m_digit + 1) % 16) begin
            m_dir = 1; m_dirr = up ? 0 : 1;
          end else if (v == (m_digit + 15) % 16) begin
            m_dir = 0; m_dirr = up ? 1 : 0;
          end else m_step = 1;
        end
        m_digit = v;
        m_valid = 1;
      end
      if (m_accept != 0 && m_chg < CNT_MAX) m_chg++;
      if ((m_illegal | m_step | m_dirr) != 0 && m_err < CNT_MAX) m_err++;
    end
  endtask

  int row_acc = 0;
  int row_err = 0;

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("digit",       digit,       m_digit);
    check("digit_dp",    digit_dp,    m_dp);
    check("digit_valid", digit_valid, m_valid);
    check("dir",         dir,         m_dir);
    check("accept",      accept,      m_accept);
    check("illegal",     illegal,     m_illegal);
    check("step_err",    step_err,    m_step);
    check("dir_err",     dir_err,     m_dirr);
    check("chg_cnt",     chg_cnt,     m_chg);
    check("err_cnt",     err_cnt,     m_err);
    row_acc += int'(accept);
    row_err += int'(illegal) + int'(step_err) + int'(dir_err);
  endtask

  typedef struct {
    logic [6:0] seg;
    logic       view;
    logic       up;
    int         cycles;
    int         exp_digit;
    logic       exp_dir;
    int         exp_acc;
    int         exp_err;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] s, input logic vw, input logic u,
                              input int cyc, input int d, input logic dr,
                              input int a, input int e);
    vec_t r;
    r.seg = s; r.view = vw; r.up = u; r.cycles = cyc;
    r.exp_digit = d; r.exp_dir = dr; r.exp_acc = a; r.exp_err = e;
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    int n;
    int k;
    int hold;
    logic [6:0] pat;

    // up run 1..F then wrap to 0
    for (int v = 1; v < 16; v++) vecs.push_back(mk(glyph[v], 1'b1, 1'b1, 8, v, 1'b1, 1, 0));
    vecs.push_back(mk(glyph[0], 1'b1, 1'b1, 8, 0, 1'b1, 1, 0));
    // climb to 3, legal down step, then a down step while commanded up
    for (int v = 1; v < 4; v++) vecs.push_back(mk(glyph[v], 1'b1, 1'b1, 8, v, 1'b1, 1, 0));
    vecs.push_back(mk(glyph[2], 1'b1, 1'b0, 8, 2, 1'b0, 1, 0));
    vecs.push_back(mk(glyph[1], 1'b1, 1'b1, 8, 1, 1'b0, 1, 1));
    // climb to 5, short glitch, same value again, then an illegal pattern
    for (int v = 2; v < 6; v++) vecs.push_back(mk(glyph[v], 1'b1, 1'b1, 8, v, 1'b1, 1, 0));
    vecs.push_back(mk(glyph[5],   1'b1, 1'b1, 8, 5, 1'b1, 0, 0));
    vecs.push_back(mk(glyph[8],   1'b1, 1'b1, 2, 5, 1'b1, 0, 0));
    vecs.push_back(mk(glyph[5],   1'b1, 1'b1, 6, 5, 1'b1, 0, 0));
    vecs.push_back(mk(7'b1111110, 1'b1, 1'b1, 6, 5, 1'b1, 0, 1));
    // down to 4, then 4 -> 7 step error (digit resyncs, dir held)
    vecs.push_back(mk(glyph[4], 1'b1, 1'b0, 8, 4, 1'b0, 1, 0));
    vecs.push_back(mk(glyph[7], 1'b1, 1'b1, 8, 7, 1'b0, 1, 1));
    // up to 9 ahead of the view gap
    vecs.push_back(mk(glyph[8], 1'b1, 1'b1, 8, 8, 1'b1, 1, 0));
    vecs.push_back(mk(glyph[9], 1'b1, 1'b1, 8, 9, 1'b1, 1, 0));

    // reset held 3 cycles with '0' on the display
    reset = 1'b1; seg = glyph[0]; dp = 1'b1; view = 1'b1; up = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_digit", digit, 0);
      check("rst_valid", digit_valid, 0);
      check("rst_chg",   chg_cnt, 0);
      check("rst_err",   err_cnt, 0);
    end
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check($sformatf("t1_accept_edge%0d", i), accept, (i == 4) ? 1 : 0);
    end
    check("t1_digit", digit, 0);
    check("t1_valid", digit_valid, 1);
    check("t1_chg",   chg_cnt, 1);

    foreach (vecs[i]) begin
      seg = vecs[i].seg; view = vecs[i].view; up = vecs[i].up; dp = 1'b1;
      row_acc = 0; row_err = 0;
      repeat (vecs[i].cycles) tick();
      check($sformatf("row%0d_digit", i), digit,   vecs[i].exp_digit);
      check($sformatf("row%0d_dir",   i), dir,     vecs[i].exp_dir);
      check($sformatf("row%0d_acc",   i), row_acc, vecs[i].exp_acc);
      check($sformatf("row%0d_err",   i), row_err, vecs[i].exp_err);
    end

    // view gap: 'A' on the blanked display is invisible until view returns
    view = 1'b0; seg = glyph[10]; up = 1'b1;
    row_acc = 0; row_err = 0;
    repeat (10) tick();
    check("gap_acc",   row_acc, 0);
    check("gap_err",   row_err, 0);
    check("gap_digit", digit, 9);
    view = 1'b1;
    n = -1;
    for (int i = 1; i <= 10 && n < 0; i++) begin
      tick();
      if (accept === 1'b1) n = i;
    end
    check("t6_latency", n, 4);
    check("t6_digit", digit, 10);
    check("t6_dir",   dir, 1);

    // randomized traffic, mostly plausible steps with occasional junk
    for (int r = 0; r < 250; r++) begin
      reset = ($urandom_range(0, 99) < 2);
      view  = ($urandom_range(0, 9) != 0);
      up    = 1'($urandom_range(0, 1));
      dp    = 1'($urandom_range(0, 1));
      k     = $urandom_range(0, 9);
      if (k < 4)      pat = glyph[(m_digit + 1) % 16];
      else if (k < 7) pat = glyph[(m_digit + 15) % 16];
      else if (k < 8) pat = glyph[$urandom_range(0, 15)];
      else if (k < 9) pat = 7'($urandom);
      else            pat = BLANK;
      seg  = pat;
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        tick();
        reset = 1'b0;
      end
    end

    // counter saturation: alternating 0/8 gives an accept and a step error each time
    reset = 1'b1; view = 1'b1; up = 1'b1; dp = 1'b1; seg = glyph[0];
    tick();
    reset = 1'b0;
    for (int i = 0; i < 300; i++) begin
      seg = glyph[(i % 2) * 8];
      repeat (4) tick();
    end
    check("sat_chg", chg_cnt, CNT_MAX);
    check("sat_err", err_cnt, CNT_MAX);

    // reset mid-operation clears everything regardless of seg
    reset = 1'b1; seg = glyph[3];
    tick();
    check("midrst_digit", digit, 0);
    check("midrst_valid", digit_valid, 0);
    check("midrst_chg",   chg_cnt, 0);
    check("midrst_err",   err_cnt, 0);
    reset = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
